// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: formats one load/store per instruction,
// runs it over a req/ack handshake and stalls upstream until it completes.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        result_valid,
  output logic        misalign_exc,
  output logic        bus_err
);

  // state | meaning
  // IDLE  | waiting for an access; illegal accesses flagged here
  // BUSY  | dmem_req held, waiting for ack or timeout
  // DONE  | result_valid (and bus_err on timeout) for one cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              signed_q;

  logic              access;
  logic              bad;
  logic              accept;
  logic              timeout_hit;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       lane;
  logic [31:0]       load_fmt;

  assign access = mem_read | mem_write;
  assign bad    = (mem_read & mem_write) | (mem_size == 2'b11) |
                  ((mem_size == SZ_HALF) & addr[0]) |
                  ((mem_size == SZ_WORD) & (addr[1:0] != 2'b00));
  assign accept = (state == IDLE) & access & ~bad;
  assign timeout_hit = (cnt == CNT_LAST);

  // Gated by rst_n so an asserted reset releases the pipeline immediately,
  // even while the held instruction is still presented.
  assign stall = rst_n & (accept | (state == BUSY));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (mem_size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  always_comb begin
    lane     = dmem_rdata >> {off_q, 3'b000};
    load_fmt = dmem_rdata;
    case (size_q)
      SZ_BYTE: load_fmt = {{24{signed_q & lane[7]}}, lane[7:0]};
      SZ_HALF: load_fmt = {{16{signed_q & lane[15]}}, lane[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (dmem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      load_data    <= '0;
      result_valid <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (access && bad) begin
            misalign_exc <= 1'b1;
          end else if (accept) begin
            cnt        <= '0;
            off_q      <= addr[1:0];
            size_q     <= mem_size;
            signed_q   <= mem_signed;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            load_data    <= dmem_we ? 32'h0 : load_fmt;
            result_valid <= 1'b1;
          end else if (timeout_hit) begin
            dmem_req     <= 1'b0;
            load_data    <= 32'h0;
            bus_err      <= 1'b1;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a queue-based scoreboard checks every
// result_valid / misalign_exc event independently of the stimulus.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_signed = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, load_data;
  logic [3:0]  dmem_be;
  logic        result_valid, misalign_exc, bus_err;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_signed(mem_signed), .addr(addr), .wdata(wdata),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .load_data(load_data), .result_valid(result_valid),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic        berr;
    logic [31:0] ld;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (dmem_req) req_cnt++;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (result_valid || misalign_exc)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: rv=%b exc=%b with empty queue", result_valid, misalign_exc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("misalign_exc", {31'b0, misalign_exc}, {31'b0, e.exc});
        check("result_valid", {31'b0, result_valid}, {31'b0, ~e.exc});
        check("bus_err", {31'b0, bus_err}, {31'b0, e.berr});
        if (!e.exc) check("load_data", load_data, e.ld);
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg; addr = a; wdata = wd;
  endtask

  // ack_at: BUSY cycle (1-based) on which ack is given; 0 = never (timeout)
  task automatic do_access(input string nm, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rword,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_ld);
    int nb;
    exp_t e;
    nb = (ack_at == 0) ? TIMEOUT : ack_at;
    e.exc = 1'b0; e.berr = (ack_at == 0); e.ld = (ack_at == 0) ? 32'h0 : exp_ld;
    q.push_back(e);
    @(posedge clk); #1;
    stall_cnt = 0; req_cnt = 0;
    drive(rd, wr, sz, sg, a, wd);
    #1 check({nm, "_stall_accept"}, {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    check({nm, "_req"}, {31'b0, dmem_req}, 32'h1);
    check({nm, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    check({nm, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
    check({nm, "_we"}, {31'b0, dmem_we}, {31'b0, wr});
    if (wr) check({nm, "_wdata"}, dmem_wdata, exp_wd);
    for (int k = 1; k <= nb; k++) begin
      dmem_ack = (k == ack_at);
      dmem_rdata = rword;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check({nm, "_stall_cycles"}, stall_cnt, nb + 1);
    check({nm, "_req_cycles"}, req_cnt, nb);
  endtask

  task automatic do_bad(input string nm, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic [31:0] a);
    exp_t e;
    e.exc = 1'b1; e.berr = 1'b0; e.ld = 32'h0;
    q.push_back(e);
    @(posedge clk); #1;
    stall_cnt = 0; req_cnt = 0;
    drive(rd, wr, sz, 1'b0, a, 32'hCAFE_F00D);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check({nm, "_stall"}, stall_cnt, 0);
    check({nm, "_req"}, req_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_outs", {dmem_be, 1'b0, dmem_we, result_valid, misalign_exc, bus_err, stall, 22'b0},
          32'h0);
    check("rst_load", load_data | dmem_addr | dmem_wdata, 32'h0);
    rst_n = 1'b1;

    do_access("ldw", 1, 0, 2'b10, 0, 32'h0000_1004, 0, 3, 32'hDEAD_BEEF,
              4'b1111, 32'h0, 32'hDEAD_BEEF);
    do_access("ldb_s", 1, 0, 2'b00, 1, 32'h0000_2003, 0, 1, 32'h80FF_1234,
              4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access("ldb_u", 1, 0, 2'b00, 0, 32'h0000_2003, 0, 1, 32'h80FF_1234,
              4'b1000, 32'h0, 32'h0000_0080);
    do_access("ldh_s", 1, 0, 2'b01, 1, 32'h0000_2002, 0, 2, 32'h80FF_1234,
              4'b1100, 32'h0, 32'hFFFF_80FF);
    do_access("ldh_u0", 1, 0, 2'b01, 0, 32'h0000_2000, 0, 1, 32'h80FF_F234,
              4'b0011, 32'h0, 32'h0000_F234);
    do_access("sth", 0, 1, 2'b01, 0, 32'h0000_3002, 32'h1111_ABCD, 1, 32'hFFFF_FFFF,
              4'b1100, 32'hABCD_ABCD, 32'h0);
    do_access("stb", 0, 1, 2'b00, 0, 32'h0000_0001, 32'h1234_5678, 2, 32'h0,
              4'b0010, 32'h7878_7878, 32'h0);
    do_access("stw", 0, 1, 2'b10, 0, 32'h0000_0010, 32'h0102_0304, 1, 32'h0,
              4'b1111, 32'h0102_0304, 32'h0);

    do_bad("mis_word", 1, 0, 2'b10, 32'h0000_1001);
    do_bad("rd_wr", 1, 1, 2'b10, 32'h0000_1000);
    do_bad("size11", 1, 0, 2'b11, 32'h0000_1000);
    do_bad("mis_half", 0, 1, 2'b01, 32'h0000_1003);

    do_access("tmo", 1, 0, 2'b10, 0, 32'h0000_4000, 0, 0, 32'h1234_5678,
              4'b1111, 32'h0, 32'h0);
    check("tmo_stall_after", {31'b0, stall}, 32'h0);
    do_access("ack_last", 1, 0, 2'b10, 0, 32'h0000_4004, 0, TIMEOUT, 32'h5555_AAAA,
              4'b1111, 32'h0, 32'h5555_AAAA);

    // stray ack while idle must produce no event
    @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
    @(posedge clk); #1 dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_ack_req", {31'b0, dmem_req}, 32'h0);

    // reset during the second BUSY cycle
    @(posedge clk); #1;
    drive(1, 0, 2'b10, 0, 32'h0000_5000, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, dmem_req}, 32'h0);
    check("arst_stall", {31'b0, stall}, 32'h0);
    check("arst_be_addr", {28'b0, dmem_be} | dmem_addr, 32'h0);
    check("arst_flags", {29'b0, result_valid, misalign_exc, bus_err}, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_access("post_rst", 1, 0, 2'b10, 0, 32'h0000_6008, 0, 1, 32'h0BAD_F00D,
              4'b1111, 32'h0, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    #1 check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
